// File: rtl/fsm_door_1596_pkg.sv
// Shared types and constants for the motorised door controller.
package fsm_door_1596_pkg;

    typedef enum logic [2:0] {
        UNKNOWN = 3'd0,
        OPENING = 3'd1,
        OPEN    = 3'd2,
        CLOSING = 3'd3,
        CLOSED  = 3'd4,
        ERROR   = 3'd5
    } state_t;

    localparam int DEF_MOVE_TIMEOUT = 20_000_000;

    // Moore output decode, packed as {ml, mr, light_red, light_green}
    function automatic logic [3:0] decode_out(input state_t s);
        case (s)
            OPENING: decode_out = 4'b1010;
            OPEN:    decode_out = 4'b0001;
            CLOSING: decode_out = 4'b0110;
            ERROR:   decode_out = 4'b0010;
            default: decode_out = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/fsm_door_1596_sync.sv
// Plain two-flop synchronizer bank; flops clear to 0 on reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/fsm_door_1596.sv
// Moore FSM for a motorised door: two keys, two end stops, two motor enables, two lamps.
// Optional input synchronizers enabled by defining DOOR_IN_SYNC_EN.
module fsm_door_1596
    import fsm_door_1596_pkg::*;
#(
    parameter int MOVE_TIMEOUT = DEF_MOVE_TIMEOUT
) (
    input  logic clk2m,
    input  logic rst,
    input  logic key_up,
    input  logic key_down,
    input  logic sense_up,
    input  logic sense_down,
    output logic ml,
    output logic mr,
    output logic light_red,
    output logic light_green
);

    localparam int TW = $clog2(MOVE_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(MOVE_TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(MOVE_TIMEOUT);

    logic   w_ku, w_kd, w_su, w_sd;
    logic   w_up_req, w_dn_req, w_tmo;
    state_t w_nxt;

    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [3:0]    r_out;

`ifdef DOOR_IN_SYNC_EN
    sync_2ff #(.WIDTH(4)) u_sync (
        .clk (clk2m),
        .rst (rst),
        .d   ({key_up, key_down, sense_up, sense_down}),
        .q   ({w_ku, w_kd, w_su, w_sd})
    );
`else
    assign {w_ku, w_kd, w_su, w_sd} = {key_up, key_down, sense_up, sense_down};
`endif

    assign w_up_req = w_ku & ~w_kd;
    assign w_dn_req = w_kd & ~w_ku;
    // Timer holds the number of cycles already spent in the move, so this edge is the last allowed
    assign w_tmo    = (r_timer >= TMO_LAST);

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            UNKNOWN: begin
                if (w_up_req)      w_nxt = w_su ? OPEN : OPENING;
                else if (w_dn_req) w_nxt = w_sd ? CLOSED : CLOSING;
            end
            OPENING: begin
                if (w_su)          w_nxt = OPEN;
                else if (w_dn_req) w_nxt = CLOSING;
                else if (w_tmo)    w_nxt = ERROR;
            end
            OPEN:    if (w_dn_req) w_nxt = CLOSING;
            CLOSING: begin
                if (w_sd)          w_nxt = CLOSED;
                else if (w_up_req) w_nxt = OPENING;
                else if (w_tmo)    w_nxt = ERROR;
            end
            CLOSED:  if (w_up_req) w_nxt = OPENING;
            ERROR:   w_nxt = ERROR;
            default: w_nxt = ERROR;
        endcase
        // Both end stops active is physically impossible: treat as a sensor fault
        if (r_state != ERROR && w_su && w_sd)
            w_nxt = ERROR;
    end

    always_ff @(posedge clk2m or posedge rst) begin
        if (rst) begin
            r_state <= UNKNOWN;
            r_timer <= '0;
            r_out   <= 4'b0000;
        end else begin
            r_state <= w_nxt;
            r_out   <= decode_out(w_nxt);
            if (w_nxt != r_state)
                r_timer <= '0;
            else if ((r_state == OPENING || r_state == CLOSING) && r_timer != TMO_MAX)
                r_timer <= r_timer + 1'b1;
        end
    end

    assign {ml, mr, light_red, light_green} = r_out;

endmodule

// File: tb/tb_fsm_door_1596.sv
// Scoreboard bench for fsm_door_1596 (MOVE_TIMEOUT=8, no input synchronizers).
`timescale 1ns/1ps
module tb_fsm_door_1596;

    localparam int MT = 8;

    logic clk2m = 1'b0;
    logic rst = 1'b1;
    logic key_up = 1'b0, key_down = 1'b0, sense_up = 1'b0, sense_down = 1'b0;
    logic ml, mr, light_red, light_green;

    int checks = 0;
    int errors = 0;
    logic [3:0] q_exp[$];

    // Reference model: door motion direction, last known end position, fault flag
    int m_dir;   // +1 moving up, -1 moving down, 0 stopped
    int m_pos;   // 0 unknown, 1 at top, 2 at bottom
    int m_t;     // edges spent in the current move
    bit m_err;

    fsm_door_1596 #(.MOVE_TIMEOUT(MT)) dut (
        .clk2m(clk2m), .rst(rst),
        .key_up(key_up), .key_down(key_down),
        .sense_up(sense_up), .sense_down(sense_down),
        .ml(ml), .mr(mr), .light_red(light_red), .light_green(light_green)
    );

    always #250 clk2m = ~clk2m;

    function automatic logic [3:0] model_out();
        logic o_ml, o_mr, o_red, o_grn;
        o_ml  = (m_dir > 0);
        o_mr  = (m_dir < 0);
        o_red = m_err || (m_dir != 0);
        o_grn = !m_err && (m_dir == 0) && (m_pos == 1);
        return {o_ml, o_mr, o_red, o_grn};
    endfunction

    task automatic model_step(input bit r, ku, kd, su, sd);
        bit up, dn, reach, rev;
        if (r) begin
            m_err = 0; m_dir = 0; m_pos = 0; m_t = 0;
            return;
        end
        if (m_err) return;
        up = ku && !kd;
        dn = kd && !ku;
        if (su && sd) begin
            m_err = 1; m_dir = 0;
            return;
        end
        if (m_dir == 0) begin
            if (m_pos == 0) begin
                if (up) begin
                    if (su) m_pos = 1; else begin m_dir = 1; m_t = 0; end
                end else if (dn) begin
                    if (sd) m_pos = 2; else begin m_dir = -1; m_t = 0; end
                end
            end else if (m_pos == 1) begin
                if (dn) begin m_dir = -1; m_t = 0; end
            end else begin
                if (up) begin m_dir = 1; m_t = 0; end
            end
        end else begin
            reach = (m_dir > 0) ? su : sd;
            rev   = (m_dir > 0) ? dn : up;
            if (reach) begin
                m_pos = (m_dir > 0) ? 1 : 2;
                m_dir = 0;
            end else if (rev) begin
                m_dir = -m_dir; m_t = 0;
            end else if (m_t + 1 >= MT) begin
                m_err = 1; m_dir = 0;
            end else begin
                m_t++;
            end
        end
    endtask

    // One cycle of stimulus: drive at the falling edge, predict the result of the next rising edge
    task automatic step(input bit r, ku, kd, su, sd);
        bit moving;
        @(negedge clk2m);
        moving = (m_dir != 0) && !m_err;
        rst = r; key_up = ku; key_down = kd; sense_up = su; sense_down = sd;
        if (r && moving) begin
            #1;
            checks++;
            if (ml !== 1'b0 || mr !== 1'b0) begin
                errors++;
                $display("FAIL async_rst: ml=%0b mr=%0b, required 0 0", ml, mr);
            end
        end
        model_step(r, ku, kd, su, sd);
        q_exp.push_back(model_out());
    endtask

    // Monitor: every rising edge the DUT presents a new registered output
    initial begin
        logic [3:0] exp_v, got;
        forever begin
            @(posedge clk2m);
            #2;
            if (q_exp.size() > 0) begin
                exp_v = q_exp.pop_front();
                got   = {ml, mr, light_red, light_green};
                checks++;
                if (got !== exp_v) begin
                    errors++;
                    $display("FAIL outputs @%0t: {ml,mr,red,green}=%b, required %b", $time, got, exp_v);
                end
                checks++;
                if (ml === 1'b1 && mr === 1'b1) begin
                    errors++;
                    $display("FAIL motor_excl @%0t: ml=1 mr=1, required not both", $time);
                end
            end
        end
    end

    initial begin
        m_err = 0; m_dir = 0; m_pos = 0; m_t = 0;
        #600;
        checks++;
        if ({ml, mr, light_red, light_green} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold: outputs=%b, required 0000", {ml, mr, light_red, light_green});
        end
        // Reset release, idle
        step(1, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        // Full open/close cycle
        repeat (2) step(0, 1, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 1, 0);
        repeat (2) step(0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 1);
        // Reversals
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        // Both keys in UNKNOWN and in CLOSED
        step(1, 0, 0, 0, 0);
        repeat (3) step(0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 1);
        repeat (3) step(0, 1, 1, 0, 0);
        // Timeout while opening, then sticky ERROR
        step(0, 1, 0, 0, 0);
        repeat (12) step(0, 0, 0, 0, 0);
        repeat (2) step(0, 1, 0, 1, 0);
        step(0, 0, 1, 0, 0);
        // Sensor conflict in OPEN
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0);
        // Async reset mid-opening
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // Randomized traffic with sparse sensors, rare conflicts and resets
        for (int i = 0; i < 1500; i++) begin
            bit r, ku, kd, su, sd;
            r  = ($urandom_range(99) < 3);
            ku = ($urandom_range(99) < 25);
            kd = ($urandom_range(99) < 25);
            su = ($urandom_range(99) < 10);
            sd = ($urandom_range(99) < 10);
            if (su && sd && $urandom_range(9) != 0) sd = 0;
            step(r, ku, kd, su, sd);
        end
        repeat (2) @(posedge clk2m);
        #10;
        checks++;
        if (q_exp.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q_exp.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
